// File: rtl/fetch_decode_queue_pkg.sv
// Shared pipeline definitions for the 16-bit RISC core.
//   DATA_W          : instruction / PC width
//   NOP             : instruction encoding presented to Decode when nothing is queued
//   fetch_packet_t  : {PCTwo, instruction} pair passed from Fetch towards Decode
package fetch_decode_queue_pkg;

    localparam int unsigned DATA_W = 16;

    localparam logic [DATA_W-1:0] NOP = 16'h0000;

    typedef struct packed {
        logic [DATA_W-1:0] pc_two;
        logic [DATA_W-1:0] instruction;
    } fetch_packet_t;

endpackage

// File: rtl/fetch_decode_queue_storage.sv
// Entry storage for the fetch/decode queue: DEPTH x WIDTH register file.
// Ports:
//   clk      : rising-edge clock
//   wr_en    : write strobe, wr_data stored at wr_addr on the clock edge
//   wr_addr  : write slot
//   wr_data  : entry to store
//   rd_addr  : read slot
//   rd_data  : asynchronous read of the slot at rd_addr
// Contents are deliberately not reset; occupancy tracking in the parent makes
// stale slots unobservable.
module fetch_decode_queue_storage #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_decode_queue.sv
// Instruction prefetch queue between Fetch and Decode.
// Buffers up to DEPTH {PC+2, instruction} pairs captured on Fetch cache hits and
// presents them in order to Decode under a valid/ready handshake. A taken
// branch (inp_flush) discards everything buffered plus the entry on the wire.
// Ports:
//   inp_clk, inp_rst_n : clock, asynchronous active-low reset
//   inp_hit            : Fetch offers inp_instruction / inp_PCTwo this cycle
//   inp_flush          : taken branch, kill all contents (beats push and pop)
//   inp_decodeReady    : Decode consumes the head entry this cycle
//   out_ready          : queue can take a push; Fetch holds its PC when low
//   out_valid          : head entry valid
//   out_instruction    : head instruction, NOP when empty
//   out_PCTwo          : head PC+2, zero when empty
//   out_count          : occupancy 0..DEPTH
module fetch_decode_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned PTR_W  = $clog2(DEPTH),
    parameter int unsigned DATA_W = fetch_decode_queue_pkg::DATA_W
) (
    input  logic              inp_clk,
    input  logic              inp_rst_n,
    input  logic              inp_hit,
    input  logic [DATA_W-1:0] inp_instruction,
    input  logic [DATA_W-1:0] inp_PCTwo,
    input  logic              inp_flush,
    input  logic              inp_decodeReady,
    output logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_instruction,
    output logic [DATA_W-1:0] out_PCTwo,
    output logic [PTR_W:0]    out_count
);

    import fetch_decode_queue_pkg::*;

    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W:0]      count;
    logic                push;
    logic                pop;
    logic [2*DATA_W-1:0] head_pkt;

    // Both flags come from registered count only, so Fetch never sees a
    // combinational path from Decode's ready.
    assign out_ready = (count != FULL_COUNT);
    assign out_valid = (count != '0);

    assign push = inp_hit & out_ready & ~inp_flush;
    assign pop  = out_valid & inp_decodeReady & ~inp_flush;

    fetch_decode_queue_storage #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .WIDTH (2 * DATA_W)
    ) u_storage (
        .clk     (inp_clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data ({inp_PCTwo, inp_instruction}),
        .rd_addr (rd_ptr),
        .rd_data (head_pkt)
    );

    assign out_instruction = out_valid ? head_pkt[DATA_W-1:0] : DATA_W'(NOP);
    assign out_PCTwo       = out_valid ? head_pkt[2*DATA_W-1:DATA_W] : '0;
    assign out_count       = count;

    always_ff @(posedge inp_clk or negedge inp_rst_n) begin
        if (!inp_rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (inp_flush) begin
            // Snapping rd_ptr onto wr_ptr empties the queue without touching storage.
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Self-checking bench for fetch_decode_queue: directed scenarios followed by a
// randomized run, all compared against a queue-based reference model.
module tb_fetch_decode_queue;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned PTR_W  = 2;
    localparam int unsigned DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              hit;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc_two;
    logic              flush;
    logic              dec_ready;
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_instruction;
    logic [DATA_W-1:0] out_PCTwo;
    logic [PTR_W:0]    out_count;

    int checks   = 0;
    int failures = 0;

    // Reference model: entries held as {pc_two, instr}, head at index 0.
    logic [31:0] model_q[$];

    always #5 clk = ~clk;

    fetch_decode_queue #(
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W),
        .DATA_W (DATA_W)
    ) dut (
        .inp_clk         (clk),
        .inp_rst_n       (rst_n),
        .inp_hit         (hit),
        .inp_instruction (instr),
        .inp_PCTwo       (pc_two),
        .inp_flush       (flush),
        .inp_decodeReady (dec_ready),
        .out_ready       (out_ready),
        .out_valid       (out_valid),
        .out_instruction (out_instruction),
        .out_PCTwo       (out_PCTwo),
        .out_count       (out_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against what the model says the queue holds.
    task automatic check_model(input string tag);
        logic [31:0] head;
        int unsigned n;
        n    = model_q.size();
        head = (n != 0) ? model_q[0] : 32'h0;
        check({tag, ".count"}, 32'(out_count), n);
        check({tag, ".valid"}, 32'(out_valid), (n != 0) ? 32'd1 : 32'd0);
        check({tag, ".ready"}, 32'(out_ready), (n < DEPTH) ? 32'd1 : 32'd0);
        check({tag, ".instr"}, 32'(out_instruction), 32'(head[15:0]));
        check({tag, ".pc"},    32'(out_PCTwo), 32'(head[31:16]));
    endtask

    // Apply one cycle of inputs (called just after a falling edge), advance the
    // model on the rising edge and check on the following falling edge.
    task automatic step(input logic h, input logic [15:0] i, input logic [15:0] p,
                        input logic f, input logic d, input string tag);
        bit do_push;
        bit do_pop;
        hit       = h;
        instr     = i;
        pc_two    = p;
        flush     = f;
        dec_ready = d;
        do_push   = h && (model_q.size() < DEPTH) && !f;
        do_pop    = d && (model_q.size() != 0) && !f;
        @(posedge clk);
        if (f) begin
            model_q.delete();
        end else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back({p, i});
        end
        @(negedge clk);
        hit       = 1'b0;
        flush     = 1'b0;
        dec_ready = 1'b0;
        check_model(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        hit       = 1'b0;
        instr     = '0;
        pc_two    = '0;
        flush     = 1'b0;
        dec_ready = 1'b0;

        // Outputs while held in reset.
        #12;
        check("in_reset.valid", 32'(out_valid), 32'd0);
        check("in_reset.ready", 32'(out_ready), 32'd1);
        check("in_reset.count", 32'(out_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset.
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, "idle");
        check("idle.instr_nop", 32'(out_instruction), 32'h0000);

        // Single push, then pop.
        step(1'b1, 16'h1234, 16'h0002, 1'b0, 1'b0, "push1");
        check("push1.instr", 32'(out_instruction), 32'h1234);
        check("push1.pc", 32'(out_PCTwo), 32'h0002);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, "pop1");
        check("pop1.count", 32'(out_count), 32'd0);

        // Fill to full; the fifth hit is refused.
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 16'hA000 + 16'(k), 16'h0100 + 16'(2 * k), 1'b0, 1'b0, "fill");
        end
        check("full.count", 32'(out_count), 32'd4);
        check("full.ready", 32'(out_ready), 32'd0);
        // Hit plus pop while full: pop happens, push does not.
        step(1'b1, 16'hA0FF, 16'h0, 1'b0, 1'b1, "full_pop");
        check("full_pop.count", 32'(out_count), 32'd3);
        check("full_pop.head", 32'(out_instruction), 32'hA002);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, "drain");
        end

        // Simultaneous push/pop at count 2 across pointer wrap.
        step(1'b1, 16'hC000, 16'h0200, 1'b0, 1'b0, "pp_pre");
        step(1'b1, 16'hC001, 16'h0202, 1'b0, 1'b0, "pp_pre");
        for (int k = 2; k < 8; k++) begin
            step(1'b1, 16'hC000 + 16'(k), 16'h0200 + 16'(2 * k), 1'b0, 1'b1, "pushpop");
            check("pushpop.count", 32'(out_count), 32'd2);
        end

        // Flush beats hit and pop.
        step(1'b1, 16'h5555, 16'h0300, 1'b0, 1'b0, "to3");
        step(1'b1, 16'hBEEF, 16'h0400, 1'b1, 1'b1, "flush");
        check("flush.valid", 32'(out_valid), 32'd0);
        step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, "flush_empty");
        step(1'b1, 16'h7777, 16'h0500, 1'b0, 1'b0, "post_flush");
        check("post_flush.head", 32'(out_instruction), 32'h7777);

        // Asynchronous reset between edges at count 3.
        step(1'b1, 16'h7778, 16'h0502, 1'b0, 1'b0, "pre_rst");
        step(1'b1, 16'h7779, 16'h0504, 1'b0, 1'b0, "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        model_q.delete();
        check("async_rst.valid", 32'(out_valid), 32'd0);
        check("async_rst.count", 32'(out_count), 32'd0);
        #4;
        rst_n = 1'b1;
        @(negedge clk);
        step(1'b1, 16'h0042, 16'h0600, 1'b0, 1'b0, "after_rst");
        check("after_rst.head", 32'(out_instruction), 32'h0042);
        check("after_rst.count", 32'(out_count), 32'd1);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(99) < 70) ? 1'b1 : 1'b0,
                 16'($urandom), 16'($urandom),
                 ($urandom_range(99) < 5) ? 1'b1 : 1'b0,
                 ($urandom_range(99) < 55) ? 1'b1 : 1'b0,
                 "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
- Instruction prefetch queue between the Fetch stage and the Decode stage of the 16-bit RISC pipeline.
- Captures each {PC+2, instruction} pair that Fetch delivers on a cache hit, buffers up to DEPTH entries, and hands them to Decode in order under a valid/ready handshake.
- Discards all buffered and in-flight entries when a taken branch redirects the PC.
- Drives backpressure to Fetch so the PC does not advance while the queue is full.

Parameters:
- DEPTH, 4, number of entries; must be a power of 2, minimum 2.
- PTR_W, 2, pointer width; equals log2(DEPTH).
- DATA_W, 16, instruction and PC width.

Ports:
- inp_clk  input  1  rising-edge clock, shared with Fetch.
- inp_rst_n  input  1  asynchronous reset, active low.
- inp_hit  input  1  Fetch has a valid instruction this cycle (cache hit).
- inp_instruction  input  DATA_W  instruction word from Fetch.
- inp_PCTwo  input  DATA_W  PC+2 of that instruction.
- inp_flush  input  1  taken branch (same signal as Fetch pcSrc); kill all contents.
- inp_decodeReady  input  1  Decode accepts the head entry this cycle.
- out_ready  output  1  queue can accept a push; gates the Fetch PC update.
- out_valid  output  1  head entry is valid.
- out_instruction  output  DATA_W  head instruction; 16'h0000 (NOP) when empty.
- out_PCTwo  output  DATA_W  head PC+2; 0 when empty.
- out_count  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (inp_rst_n low, asynchronous): read pointer, write pointer and count go to 0. Entry storage need not be reset. Outputs while reset: out_valid=0, out_ready=1, out_instruction=0, out_PCTwo=0, out_count=0.
- push = inp_hit & out_ready & ~inp_flush.
- pop = out_valid & inp_decodeReady & ~inp_flush.
- out_ready = (count != DEPTH). It depends only on registered state; there is no combinational path from inp_decodeReady.
- out_valid = (count != 0). out_instruction and out_PCTwo show the head entry when valid, else 0.
- Latency: a pushed entry becomes visible at the head on the cycle after the push edge, when the queue was empty. There is no same-cycle bypass; minimum Fetch-to-Decode latency is 1 cycle.
- Push only: store at the write pointer, write pointer +1 modulo DEPTH, count +1.
- Pop only: read pointer +1 modulo DEPTH, count -1.
- Push and pop in the same cycle: both pointers advance, count unchanged. This is legal at any occupancy 1..DEPTH-1.
- Full (count == DEPTH): out_ready=0, so no push occurs even if Decode pops that cycle. The freed slot is visible on the next cycle.
- Empty (count == 0): pop is impossible. A push while empty raises out_valid on the next cycle.
- Flush has priority over push and pop. On the flush edge the read pointer takes the write pointer's value and count goes to 0. The head is not consumed and the Fetch entry on that cycle is dropped. The cycle after a flush shows out_valid=0.
- Flush while empty: no state change.
- Pointer wrap: pointers are PTR_W bits and wrap naturally at DEPTH-1 → 0. Count is PTR_W+1 bits and never exceeds DEPTH.
- Reset asserted mid-operation: contents are discarded immediately and asynchronously. Normal operation resumes on the first rising edge after deassertion.
- inp_hit while out_ready=0: the request is ignored. Fetch holds its PC because it observes out_ready.

Decomposition:
- Shared pipeline package holds:
  - DATA_W=16.
  - NOP encoding 16'h0000.
  - The fetch-packet typedef {PCTwo[15:0], instruction[15:0]} (32 bits), reused by the future Decode input.
- One sub-module, queue_storage: DEPTH x 32-bit register file with one write port and one asynchronous read port.
- Pointer, count and flush control stay in the top module.

Test Plan:
- Reset then idle: deassert inp_rst_n, no stimulus → out_valid=0, out_ready=1, out_count=0, out_instruction=0000.
- Single push/pop: inp_hit=1 with instr=1234, PCTwo=0002 for one cycle, inp_decodeReady=0 → next cycle out_valid=1, out_instruction=1234, out_PCTwo=0002, out_count=1. Raise inp_decodeReady → following cycle out_count=0, out_valid=0.
- Fill to full: 5 consecutive hits with instr A001..A005, decode stalled → out_count=4, out_ready=0 after the 4th edge; A005 is not stored. Draining yields A001..A004 in order.
- Simultaneous push/pop: with count=2, hit plus decodeReady for 6 cycles → count stays 2. Output order is preserved across pointer wrap (write pointer passes 3→0).
- Flush priority: with count=3, assert inp_flush together with inp_hit (instr BEEF) and inp_decodeReady → next cycle out_count=0, out_valid=0. BEEF never appears at the output.
- Async reset mid-stream: with count=3, pull inp_rst_n low between clock edges → out_valid=0 and out_count=0 immediately, without waiting for a clock edge. After release, a push of 0042 appears alone at the head.
